prbs_framer: RTL and testbench
==============================

PRBS_FRAMER -- requirements
Module: prbs_framer

Interface
REQ-001 Parameter WIDTH, default 32, LFSR length; legal range 4..40.
REQ-002 Parameter TAPS, default 32'h8020_0003, WIDTH-bit feedback mask; bit i set means q[i] enters the feedback XOR.
REQ-003 Parameter SEED, default 1, nonzero WIDTH-bit reset/fallback state.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 clr  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  advance LFSR one step this cycle.
REQ-007 load  in  1  load seed_in into LFSR this cycle.
REQ-008 seed_in  in  WIDTH  seed value for load.
REQ-009 snap  in  1  request capture and framing of current LFSR state.
REQ-010 y  out  WIDTH  current LFSR state q.
REQ-011 wrap  out  1  one-cycle pulse when a step returns q to the current reference state.
REQ-012 out_valid  out  1  framed byte available.
REQ-013 out_ready  in  1  downstream accepts byte.
REQ-014 out_byte  out  8  framed byte {tag[2:0], payload[4:0]}.
REQ-015 out_last  out  1  marks final byte of a frame.
REQ-016 overrun  out  1  sticky: snap arrived while a frame was in progress.

Function
REQ-017 Step: fb = XOR of (q AND TAPS); next q = {fb, q[WIDTH-1:1]} (right shift, fb into MSB).
REQ-018 Priority per cycle: load > en > hold.
REQ-019 load with seed_in nonzero sets q = seed_in; load with seed_in = 0 sets q = SEED (all-zero lock-up state never entered).
REQ-020 Reference state = SEED after clr, updated to the loaded value on every load.
REQ-021 wrap = 1 for exactly the cycle after an en step whose result equals the reference state; wrap = 0 on load cycles.
REQ-022 NCH = ceil(WIDTH/5); chunk k = q bits [5k+4:5k], with bits above WIDTH-1 zero-padded.
REQ-023 FSM states: IDLE, SEND.
REQ-024 IDLE with snap: capture q into shadow register (value before that edge's step/load), set chunk index k = NCH-1, go to SEND.
REQ-025 SEND: out_valid = 1; out_byte = {k[2:0], chunk k of shadow}; out_last = 1 only when k = 0.
REQ-026 Byte transfer occurs on a cycle with out_valid and out_ready both 1; out_byte and out_last stay stable while out_valid = 1 and out_ready = 0.
REQ-027 A transfer with k > 0 decrements k; a transfer with k = 0 returns to IDLE with out_valid = 0 next cycle.
REQ-028 No snap is accepted on the cycle the last byte transfers; the earliest next capture is the first IDLE cycle.
REQ-029 snap in SEND is ignored for capture and sets overrun = 1, which holds until clr.
REQ-030 LFSR stepping and loading continue independently of framing; the shadow register is unaffected by them.
REQ-031 In IDLE, out_byte and out_last hold 0.

Reset
REQ-032 clr asynchronously forces: q = SEED, reference = SEED, shadow = 0, state IDLE, k = 0, out_valid = 0, out_byte = 0, out_last = 0, wrap = 0, overrun = 0.
REQ-033 clr mid-frame aborts the frame immediately; no remaining bytes are emitted after release.
REQ-034 The first step or load may occur on the first rising edge after clr deasserts.

Verification
REQ-035 WIDTH=32, TAPS=32'h8020_0003; after clr, en for 2 cycles -> y = 32'h8000_0000, then y = 32'hC000_0000.
REQ-036 WIDTH=32, q = 32'h8000_0000, snap, out_ready = 1 -> bytes C2, A0, 80, 60, 40, 20, 00; out_last only on 00; then out_valid = 0.
REQ-037 WIDTH=4, TAPS=4'b0011, SEED=1, en held -> wrap pulses on step 15 and on step 30, and on no other step.
REQ-038 load with seed_in = 0 -> y = SEED; load with seed_in = 5 followed by en -> wrap pulses when q returns to 5.
REQ-039 Hold out_ready = 0 for 3 cycles mid-frame -> out_byte stable during the stall; assert snap during the stall -> overrun = 1 and the frame completes unchanged.
REQ-040 Assert clr during the 3rd byte of a frame -> out_valid = 0 immediately, y = SEED, overrun = 0.

Source files
------------

// File: rtl/prbs_framer.sv
// Fibonacci-style PRBS generator with wrap detection and a byte framer that
// serialises a captured LFSR snapshot as tagged 5-bit chunks, MSB chunk first.
//
// state | meaning
// IDLE  | no frame pending; snap captures q and starts a frame
// SEND  | presenting chunk k of the shadow copy; ready handshake walks k to 0
module prbs_framer #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h8020_0003,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             snap,
    output logic [WIDTH-1:0] y,
    output logic             wrap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             overrun
);
    localparam int NCH = (WIDTH + 4) / 5;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nx;
    logic [2:0]       k, k_nx;
    logic             capture;
    logic [WIDTH-1:0] q, ref_state, shadow, q_step, load_val;
    logic [39:0]      padded;
    logic [4:0]       chunks [8];

    assign q_step   = {^(q & TAPS), q[WIDTH-1:1]};
    assign load_val = (seed_in != '0) ? seed_in : SEED;
    assign y        = q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q         <= SEED;
            ref_state <= SEED;
            wrap      <= 1'b0;
        end else if (load) begin
            q         <= load_val;
            ref_state <= load_val;
            wrap      <= 1'b0;
        end else if (en) begin
            q         <= q_step;
            wrap      <= (q_step == ref_state);
        end else begin
            wrap      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            k       <= 3'd0;
            shadow  <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            if (capture)
                shadow <= q;
            if (snap && state == SEND)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (snap) begin
                    capture  = 1'b1;
                    k_nx     = 3'(NCH - 1);
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (k == 3'd0)
                        state_nx = IDLE;
                    else
                        k_nx = k - 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Zero-pad the snapshot to eight 5-bit chunks; chunks at or above NCH are never selected.
    always_comb begin
        padded              = '0;
        padded[WIDTH-1:0]   = shadow;
        for (int i = 0; i < 8; i++)
            chunks[i] = padded[5*i +: 5];
    end

    always_comb begin
        out_valid = (state == SEND);
        out_byte  = 8'h00;
        out_last  = 1'b0;
        if (state == SEND) begin
            out_byte = {k, chunks[k]};
            out_last = (k == 3'd0);
        end
    end
endmodule

// File: tb/tb_prbs_framer.sv
// Self-checking bench for prbs_framer: directed vectors, stall/abort sequences,
// a 4-bit instance for wrap timing, and randomized traffic against a queue model.
module tb_prbs_framer;
    localparam logic [31:0] TAPS32 = 32'h8020_0003;
    localparam logic [31:0] SEED32 = 32'h1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 1'b1;
    logic        en = 1'b0, load = 1'b0, snap = 1'b0, out_ready = 1'b0;
    logic [31:0] seed_in = '0;
    logic [31:0] y;
    logic        wrap, out_valid, out_last, overrun;
    logic [7:0]  out_byte;

    logic        en4 = 1'b0, load4 = 1'b0;
    logic [3:0]  seed4 = '0;
    logic [3:0]  y4;
    logic        wrap4, out_valid4, out_last4, overrun4;
    logic [7:0]  out_byte4;

    int checks = 0;
    int failures = 0;

    prbs_framer u_dut (
        .clk(clk), .clr(clr), .en(en), .load(load), .seed_in(seed_in), .snap(snap),
        .y(y), .wrap(wrap), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last), .overrun(overrun)
    );

    prbs_framer #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'd1)) u_dut4 (
        .clk(clk), .clr(clr), .en(en4), .load(load4), .seed_in(seed4), .snap(1'b0),
        .y(y4), .wrap(wrap4), .out_valid(out_valid4), .out_ready(1'b1),
        .out_byte(out_byte4), .out_last(out_last4), .overrun(overrun4)
    );

    typedef struct {
        logic        en, load;
        logic [31:0] seed;
        logic        snap, rdy;
        logic [31:0] y;
        logic        vld;
        logic [7:0]  byt;
        logic        last, ovr;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Parity of tapped bits goes into the top bit after a right shift.
    function automatic logic [63:0] lfsr_step(input logic [63:0] q, input logic [63:0] taps, input int w);
        int ones = 0;
        for (int i = 0; i < w; i++)
            if (q[i] && taps[i]) ones++;
        return (q >> 1) + (64'(ones % 2) << (w - 1));
    endfunction

    task automatic step(input logic e, input logic l, input logic [31:0] s, input logic sn, input logic r);
        en = e; load = l; seed_in = s; snap = sn; out_ready = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step4(input logic e, input logic l, input logic [3:0] s);
        en4 = e; load4 = l; seed4 = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en = 0; load = 0; snap = 0; out_ready = 0; en4 = 0; load4 = 0;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic check_byte_seq(input string name, input logic [7:0] exp_b, input logic exp_last);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_byte"}, 64'(out_byte), 64'(exp_b));
        check({name, "_last"}, 64'(out_last), 64'(exp_last));
    endtask

    logic [63:0] m4;
    logic [31:0] mq, mref;
    logic        mwrap, movr;
    logic [7:0]  mfr [$];
    logic [7:0]  tail [4];

    initial begin
        vt[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 8'hC2, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 8'hA0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 8'h80, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 8'h60, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 8'h40, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 8'h20, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[8] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000, 1'b0, 8'h00, 1'b0, 1'b0};

        do_reset();
        check("rst_y", 64'(y), 64'(SEED32));
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_byte", 64'(out_byte), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_y4", 64'(y4), 64'd1);

        // 4-bit maximal-length sequence: wrap only on steps 15 and 30
        m4 = 64'd1;
        for (int s = 1; s <= 31; s++) begin
            step4(1'b1, 1'b0, 4'd0);
            m4 = lfsr_step(m4, 64'h3, 4);
            check("w4_y", 64'(y4), m4);
            check("w4_wrap", 64'(wrap4), 64'((s == 15) || (s == 30)));
        end
        step4(1'b0, 1'b1, 4'd0);
        check("w4_load0_y", 64'(y4), 64'd1);
        check("w4_load0_wrap", 64'(wrap4), 64'd0);
        step4(1'b0, 1'b1, 4'd5);
        check("w4_load5_y", 64'(y4), 64'd5);
        m4 = 64'd5;
        for (int s = 1; s <= 16; s++) begin
            step4(1'b1, 1'b0, 4'd0);
            m4 = lfsr_step(m4, 64'h3, 4);
            check("w4r_y", 64'(y4), m4);
            check("w4r_wrap", 64'(wrap4), 64'(s == 15));
        end
        en4 = 1'b0;
        check("w4_idle_valid", 64'(out_valid4), 64'd0);
        check("w4_idle_byte", 64'(out_byte4), 64'd0);
        check("w4_idle_last", 64'(out_last4), 64'd0);
        check("w4_idle_ovr", 64'(overrun4), 64'd0);

        // Directed vector table on the 32-bit instance
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(vt[i].en, vt[i].load, vt[i].seed, vt[i].snap, vt[i].rdy);
            check($sformatf("vec%0d_y", i), 64'(y), 64'(vt[i].y));
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].vld));
            check($sformatf("vec%0d_byte", i), 64'(out_byte), 64'(vt[i].byt));
            check($sformatf("vec%0d_last", i), 64'(out_last), 64'(vt[i].last));
            check($sformatf("vec%0d_ovr", i), 64'(overrun), 64'(vt[i].ovr));
        end

        // Stall mid-frame with a snap during the stall; q = C0000000 -> C3 A0 80 60 40 20 00
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_byte_seq("st0", 8'hC3, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_byte_seq("st1", 8'hA0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_byte_seq("st2", 8'h80, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, (i == 1), 1'b0);
            check_byte_seq("stall", 8'h80, 1'b0);
            check("stall_ovr", 64'(overrun), 64'(i >= 1));
        end
        tail = '{8'h60, 8'h40, 8'h20, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check_byte_seq("tail", tail[i], (i == 3));
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("post_frame_valid", 64'(out_valid), 64'd0);
        check("post_frame_byte", 64'(out_byte), 64'd0);

        // Abort with clr while the 3rd byte is presented
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_byte_seq("abort_pre", 8'h80, 1'b0);
        out_ready = 1'b0;
        #2 clr = 1'b1;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_y", 64'(y), 64'(SEED32));
        check("abort_ovr", 64'(overrun), 64'd0);
        check("abort_byte", 64'(out_byte), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check("abort_after_valid", 64'(out_valid), 64'd0);
        end

        // Randomized traffic against a queue-based frame model
        do_reset();
        mq = SEED32; mref = SEED32; mwrap = 1'b0; movr = 1'b0; mfr.delete();
        for (int c = 0; c < 1600; c++) begin
            logic e, l, sn, r, sending;
            logic [31:0] s;
            if (c == 800) begin
                do_reset();
                mq = SEED32; mref = SEED32; mwrap = 1'b0; movr = 1'b0; mfr.delete();
                check("rnd_rst_valid", 64'(out_valid), 64'd0);
            end
            e  = ($urandom_range(0, 9) < 6);
            l  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            sn = ($urandom_range(0, 11) == 0);
            r  = ($urandom_range(0, 9) < 7);
            en = e; load = l; seed_in = s; snap = sn; out_ready = r;

            sending = (mfr.size() != 0);
            if (sending && r) void'(mfr.pop_front());
            if (sn) begin
                if (sending) movr = 1'b1;
                else
                    for (int k = 6; k >= 0; k--)
                        mfr.push_back(8'(k * 32 + ((mq >> (5 * k)) % 32)));
            end
            if (l) begin
                mq = (s != 0) ? s : SEED32;
                mref = mq;
                mwrap = 1'b0;
            end else if (e) begin
                mq = 32'(lfsr_step(64'(mq), 64'(TAPS32), 32));
                mwrap = (mq == mref);
            end else begin
                mwrap = 1'b0;
            end

            @(posedge clk);
            @(negedge clk);
            check("rnd_y", 64'(y), 64'(mq));
            check("rnd_wrap", 64'(wrap), 64'(mwrap));
            check("rnd_valid", 64'(out_valid), 64'(mfr.size() != 0));
            check("rnd_byte", 64'(out_byte), (mfr.size() != 0) ? 64'(mfr[0]) : 64'd0);
            check("rnd_last", 64'(out_last), 64'(mfr.size() == 1));
            check("rnd_ovr", 64'(overrun), 64'(movr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
